// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-bus access controller between the instruction
// decoder and the status counter. Turns the decoder's level-held MREQ_N
// strobe into exactly one req/rdy handshake with external memory. Read data
// lands in ISR (instruction fetch) or MDR_IN (data read), and a one-cycle ACK
// lets the status counter leave its memory-wait states.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a request after TIMEOUT
// REQ cycles without mem_rdy. An abort raises a sticky bus_err and still
// pulses ACK. Without the macro, REQ waits forever and bus_err stays 0.
//
// state | meaning
// IDLE  | waiting for MREQ_N=0; latches address, data and direction
// REQ   | mem_req held; waiting for mem_rdy (or timeout)
// DONE  | ACK pulse; captured read data already visible
// REL   | waiting for MREQ_N=1 so a held request is not re-issued
module mem_access_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MREQ_N,
  input  logic              R_W_N,
  input  logic              MIS,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] ISR,
  output logic [DATA_W-1:0] MDR_IN,
  output logic              ACK,
  output logic              busy,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, REL} state_t;

  state_t state;
  logic   rd_lat;
  logic   mis_lat;

`ifdef MEM_TIMEOUT_EN
  // Abort fires on the REQ cycle that would bring the count up to TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Access sequencer: state, bus outputs and capture registers in one block
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ISR       <= '0;
      MDR_IN    <= '0;
      ACK       <= 1'b0;
      busy      <= 1'b0;
      bus_err   <= 1'b0;
      rd_lat    <= 1'b0;
      mis_lat   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      to_cnt    <= 8'd0;
`endif
    end else begin
      ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (!MREQ_N) begin
            mem_addr  <= addr_in;
            mem_wdata <= wdata_in;
            mem_we    <= ~R_W_N;
            rd_lat    <= R_W_N;
            mis_lat   <= MIS;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            bus_err   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            to_cnt    <= 8'd0;
`endif
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_rdy) begin
            mem_req <= 1'b0;
            ACK     <= 1'b1;
            state   <= DONE;
            if (rd_lat) begin
              if (mis_lat) ISR <= mem_rdata;
              else         MDR_IN <= mem_rdata;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            ACK     <= 1'b1;
            state   <= DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          state <= REL;
        end
        REL: begin
          if (MREQ_N) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
